// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings and sizing helpers for the memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int WORD_W_DEF = 16;

  // Bits needed to hold the value n (at least one).
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_grant.sv
// Combinational D-over-IF priority with a starvation guard, plus the next streak value.
module arb_grant
  import mem_port_arbiter_pkg::*;
#(
  parameter int   MAX_STREAK = 3,
  localparam int  SW         = cnt_w(MAX_STREAK)
) (
  input  logic          if_req,
  input  logic          d_req,
  input  logic [SW-1:0] streak,
  output logic          grant_d,
  output logic          grant_if,
  output logic [SW-1:0] streak_next
);

  logic w_force_if;

  always_comb begin
    w_force_if  = if_req && (streak == SW'(MAX_STREAK));
    grant_if    = if_req && (!d_req || w_force_if);
    grant_d     = d_req && !grant_if;
    streak_next = streak;
    if (grant_if) begin
      streak_next = '0;
    end else if (grant_d) begin
      if (!if_req)
        streak_next = '0;
      else if (streak != SW'(MAX_STREAK))
        streak_next = streak + SW'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access: arbitrate in IDLE,
// hold the latched request on the bus for MEM_LAT cycles, then pulse the winner's ack.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int MEM_LAT    = 2,
  parameter int MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [WORD_W-1:0] if_addr,
  output logic [WORD_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [WORD_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic [WORD_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              busy,
  output logic              readM,
  output logic              writeM,
  output logic [WORD_W-1:0] address,
  inout  wire  [WORD_W-1:0] data
);

  localparam int SW = cnt_w(MAX_STREAK);
  localparam int TW = cnt_w(MEM_LAT);

  state_t            r_state, w_state_nxt;
  logic [TW-1:0]     r_timer;
  owner_t            r_owner;
  logic              r_we;
  logic [WORD_W-1:0] r_addr, r_wdata;
  logic [WORD_W-1:0] r_if_rdata, r_d_rdata;
  logic              r_if_ack, r_d_ack;
  logic              r_readM, r_writeM;
  logic [SW-1:0]     r_streak, w_streak_nxt;
  logic              w_grant_d, w_grant_if;
  logic              w_last;

  arb_grant #(.MAX_STREAK(MAX_STREAK)) u_grant (
    .if_req     (if_req),
    .d_req      (d_req),
    .streak     (r_streak),
    .grant_d    (w_grant_d),
    .grant_if   (w_grant_if),
    .streak_next(w_streak_nxt)
  );

  assign w_last = (r_timer == TW'(MEM_LAT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (if_req || d_req) w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (w_last)          w_state_nxt = ST_RESP;
      ST_RESP:                        w_state_nxt = ST_IDLE;
      default:                        w_state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are set at grant and cleared on the last access edge, so they
  // cover exactly MEM_LAT cycles and the ack lands in RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_timer    <= '0;
      r_owner    <= OWN_IF;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
      r_if_ack   <= 1'b0;
      r_d_ack    <= 1'b0;
      r_readM    <= 1'b0;
      r_writeM   <= 1'b0;
      r_streak   <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_timer <= '0;
          if (w_grant_d || w_grant_if) begin
            r_owner  <= w_grant_d ? OWN_D : OWN_IF;
            r_we     <= w_grant_d && d_we;
            r_addr   <= w_grant_d ? d_addr : if_addr;
            r_wdata  <= w_grant_d ? d_wdata : '0;
            r_readM  <= !(w_grant_d && d_we);
            r_writeM <= w_grant_d && d_we;
            r_streak <= w_streak_nxt;
          end
        end
        ST_ACCESS: begin
          r_timer <= r_timer + TW'(1);
          if (w_last) begin
            r_readM  <= 1'b0;
            r_writeM <= 1'b0;
            if (r_owner == OWN_D) begin
              r_d_ack <= 1'b1;
              if (!r_we) r_d_rdata <= data;
            end else begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= data;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign data     = r_writeM ? r_wdata : {WORD_W{1'bz}};
  assign readM    = r_readM;
  assign writeM   = r_writeM;
  assign address  = r_addr;
  assign if_rdata = r_if_rdata;
  assign d_rdata  = r_d_rdata;
  assign if_ack   = r_if_ack;
  assign d_ack    = r_d_ack;
  assign busy     = (r_state != ST_IDLE);

endmodule
